// File: rtl/pic_ctrl_pkg.sv
// Shared constants and types for the programmable interrupt controller.
// Register offsets, EOI command code, FSM encoding and a priority helper.
package pic_ctrl_pkg;

  localparam logic [1:0] OFS_CMD = 2'd0;
  localparam logic [1:0] OFS_IMR = 2'd1;
  localparam logic [1:0] OFS_ISR = 2'd2;
  localparam logic [1:0] OFS_TMR = 2'd3;

  localparam logic [7:0] EOI_CMD = 8'h20;

  typedef enum logic [0:0] {
    StIdle,
    StService
  } pic_state_e;

  // Index of the lowest set bit; line 0 has the highest priority.
  function automatic logic [2:0] lowest_idx(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/pic_ctrl_if.sv
// CPU I/O bus between a processor (master) and the interrupt controller (slave).
interface pic_ctrl_if;

  logic [15:0] port_a;
  logic        port_w;
  logic        port_r;
  logic [7:0]  port_o;
  logic [7:0]  port_i;

  modport master (
    output port_a,
    output port_w,
    output port_r,
    output port_o,
    input  port_i
  );

  modport slave (
    input  port_a,
    input  port_w,
    input  port_r,
    input  port_o,
    output port_i
  );

endinterface

// File: rtl/pic_edge.sv
// Request sampler: registers req and produces per-line IRR set pulses,
// level-style or 0->1-edge-style depending on the trigger mode of each line.
module pic_edge (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] req,
  input  logic [7:0] tmr,
  output logic [7:0] set
);

  logic [7:0] cur_q;
  logic [7:0] prev_q;
  logic [7:0] armed_q;

  // armed_q blocks edge detection on lines that were already high at reset
  // release until they have been seen low once.
  always_ff @(posedge clock) begin
    if (reset) begin
      cur_q   <= 8'h00;
      prev_q  <= 8'h00;
      armed_q <= 8'h00;
    end else begin
      cur_q   <= req;
      prev_q  <= cur_q;
      armed_q <= armed_q | ~req;
    end
  end

  assign set = (tmr & cur_q) | (~tmr & cur_q & ~prev_q & armed_q);

endmodule

// File: rtl/pic_ctrl.sv
// Eight-line interrupt controller with IRR/IMR/ISR/TMR registers, fixed
// priority (line 0 highest) and a toggle-style interrupt to the CPU.
module pic_ctrl
  import pic_ctrl_pkg::*;
#(
  parameter logic [7:0]  VECTOR_BASE = 8'h08,
  parameter logic [15:0] PORT_BASE   = 16'h0020
) (
  input  logic             clock,
  input  logic             reset,
  pic_ctrl_if.slave        bus,
  input  logic [7:0]       req,
  output logic             irq,
  output logic [7:0]       irq_in
);

  pic_state_e state_q, state_d;

  logic [7:0] irr_q, irr_d;
  logic [7:0] isr_q, isr_d;
  logic [7:0] imr_q, imr_d;
  logic [7:0] tmr_q, tmr_d;
  logic       irq_q, irq_d;
  logic [7:0] vec_q, vec_d;

  logic [7:0]  set_pulse;
  logic [15:0] offset;
  logic        hit;
  logic [1:0]  ofs;
  logic        wr_cmd, wr_imr, wr_tmr, eoi;
  logic [7:0]  pend;
  logic        grant;
  logic [2:0]  grant_idx;
  logic [7:0]  grant_oh;
  logic [7:0]  rd_data;

  // Reads have no side effects, so the strobe is not needed.
  logic unused_port_r;
  assign unused_port_r = bus.port_r;

  pic_edge u_edge (
    .clock (clock),
    .reset (reset),
    .req   (req),
    .tmr   (tmr_q),
    .set   (set_pulse)
  );

  // Wrapping subtraction keeps the decode correct for any PORT_BASE alignment.
  assign offset = bus.port_a - PORT_BASE;
  assign hit    = (offset[15:2] == 14'd0);
  assign ofs    = offset[1:0];

  assign wr_cmd = bus.port_w && hit && (ofs == OFS_CMD);
  assign wr_imr = bus.port_w && hit && (ofs == OFS_IMR);
  assign wr_tmr = bus.port_w && hit && (ofs == OFS_TMR);
  assign eoi    = wr_cmd && (bus.port_o == EOI_CMD);

  assign pend      = irr_q & ~imr_q;
  assign grant_idx = lowest_idx(pend);

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:    if (pend != 8'h00) state_d = StService;
      StService: if (eoi) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Grant, EOI and register-update logic.
  always_comb begin
    grant    = (state_q == StIdle) && (pend != 8'h00);
    grant_oh = grant ? (8'h01 << grant_idx) : 8'h00;

    // A set pulse landing on the grant edge wins over the grant clear.
    irr_d = (irr_q & ~grant_oh) | set_pulse;

    isr_d = isr_q;
    if (grant) begin
      isr_d = grant_oh;
    end else if ((state_q == StService) && eoi) begin
      isr_d = 8'h00;
    end

    irq_d = irq_q ^ grant;
    vec_d = grant ? (VECTOR_BASE + {5'b00000, grant_idx}) : vec_q;
    imr_d = wr_imr ? bus.port_o : imr_q;
    tmr_d = wr_tmr ? bus.port_o : tmr_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      irr_q <= 8'h00;
      isr_q <= 8'h00;
      imr_q <= 8'h00;
      tmr_q <= 8'h00;
      irq_q <= 1'b0;
      vec_q <= VECTOR_BASE;
    end else begin
      irr_q <= irr_d;
      isr_q <= isr_d;
      imr_q <= imr_d;
      tmr_q <= tmr_d;
      irq_q <= irq_d;
      vec_q <= vec_d;
    end
  end

  always_comb begin
    rd_data = 8'hFF;
    if (hit) begin
      case (ofs)
        OFS_CMD: rd_data = irr_q;
        OFS_IMR: rd_data = imr_q;
        OFS_ISR: rd_data = isr_q;
        OFS_TMR: rd_data = tmr_q;
        default: rd_data = 8'hFF;
      endcase
    end
  end

  assign bus.port_i = rd_data;
  assign irq        = irq_q;
  assign irq_in     = vec_q;

endmodule

// File: tb/tb_pic_ctrl.sv
// Scoreboard bench for pic_ctrl: stimulus queues expected grants (vector and
// edge number); a negedge monitor pops and compares on every irq toggle.
module tb_pic_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] req;
  logic       irq;
  logic [7:0] irq_in;

  pic_ctrl_if bus ();

  pic_ctrl #(
    .VECTOR_BASE (8'h08),
    .PORT_BASE   (16'h0020)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .bus    (bus),
    .req    (req),
    .irq    (irq),
    .irq_in (irq_in)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] vec;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks   = 0;
  int   failures = 0;
  int   ntog     = 0;
  logic irq_last = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every irq level change outside reset is one grant.
  always @(negedge clock) begin
    if (reset) begin
      irq_last = irq;
    end else begin
      if (irq !== irq_last) begin
        irq_last = irq;
        ntog++;
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_grant: got vector %0h at cycle %0d, want none", irq_in, cyc);
        end else begin
          e = sb.pop_front();
          check("grant_vec", {24'h0, irq_in}, {24'h0, e.vec});
          check("grant_cycle", cyc, e.cyc);
        end
      end
      if (sb.size() != 0 && cyc > sb[0].cyc) begin
        e = sb.pop_front();
        checks++;
        failures++;
        $display("FAIL missing_grant: got no toggle by cycle %0d, want vector %0h", e.cyc, e.vec);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [7:0] vec, input int c);
    exp_t x;
    x.vec = vec;
    x.cyc = c;
    sb.push_back(x);
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    bus.port_a = a;
    bus.port_o = d;
    bus.port_w = 1'b1;
    tick();
    bus.port_w = 1'b0;
    bus.port_a = 16'h0000;
  endtask

  task automatic rdchk(input string name, input logic [15:0] a, input logic [7:0] exp);
    logic [7:0] d;
    bus.port_a = a;
    bus.port_r = 1'b1;
    #1;
    d = bus.port_i;
    bus.port_r = 1'b0;
    bus.port_a = 16'h0000;
    check(name, {24'h0, d}, {24'h0, exp});
  endtask

  task automatic pulse(input logic [7:0] mask);
    req = mask;
    tick();
    req = 8'h00;
  endtask

  task automatic eoi();
    wr(16'h0020, 8'h20);
  endtask

  int t0, t1;

  initial begin
    reset      = 1'b1;
    req        = 8'h00;
    bus.port_a = 16'h0000;
    bus.port_w = 1'b0;
    bus.port_r = 1'b0;
    bus.port_o = 8'h00;
    tick();
    tick();
    reset = 1'b0;
    tick();
    tick();

    // Reset state and address decode.
    check("rst_irq", {31'h0, irq}, 32'h0);
    check("rst_irq_in", {24'h0, irq_in}, 32'h08);
    rdchk("rst_irr", 16'h0020, 8'h00);
    rdchk("rst_imr", 16'h0021, 8'h00);
    rdchk("rst_isr", 16'h0022, 8'h00);
    rdchk("rst_tmr", 16'h0023, 8'h00);
    rdchk("unmapped_hi", 16'h0024, 8'hFF);
    rdchk("unmapped_lo", 16'h001F, 8'hFF);

    // Single edge pulse on line 1.
    push(8'h09, cyc + 3);
    pulse(8'h02);
    tick();
    tick();
    check("t1_irq", {31'h0, irq}, 32'h1);
    rdchk("t1_isr", 16'h0022, 8'h02);
    rdchk("t1_irr", 16'h0020, 8'h00);
    wr(16'h0020, 8'h21);
    rdchk("t1_bad_cmd_isr", 16'h0022, 8'h02);
    eoi();
    rdchk("t1_eoi_isr", 16'h0022, 8'h00);

    // Simultaneous lines 0 and 2: priority, then grant after EOI.
    t0 = ntog;
    push(8'h08, cyc + 3);
    pulse(8'h05);
    tick();
    tick();
    tick();
    rdchk("t2_irr", 16'h0020, 8'h04);
    rdchk("t2_isr", 16'h0022, 8'h01);
    push(8'h0A, cyc + 2);
    eoi();
    tick();
    tick();
    tick();
    check("t2_toggles", ntog, t0 + 2);
    rdchk("t2_isr2", 16'h0022, 8'h04);
    eoi();

    // Masked line latches but is not granted until unmasked.
    wr(16'h0021, 8'h01);
    t0 = ntog;
    pulse(8'h01);
    repeat (4) tick();
    rdchk("t3_irr", 16'h0020, 8'h01);
    rdchk("t3_isr", 16'h0022, 8'h00);
    check("t3_no_toggle", ntog, t0);
    push(8'h08, cyc + 2);
    wr(16'h0021, 8'h00);
    tick();
    tick();
    check("t3_toggles", ntog, t0 + 1);
    eoi();

    // Repeated requests during service merge into one pending bit.
    push(8'h0B, cyc + 3);
    pulse(8'h08);
    tick();
    tick();
    tick();
    t0 = ntog;
    repeat (3) begin
      pulse(8'h02);
      tick();
    end
    tick();
    rdchk("t4_irr", 16'h0020, 8'h02);
    rdchk("t4_isr", 16'h0022, 8'h08);
    check("t4_no_toggle", ntog, t0);
    push(8'h09, cyc + 2);
    eoi();
    tick();
    tick();
    tick();
    check("t4_one_grant", ntog, t0 + 1);
    rdchk("t4_irr2", 16'h0020, 8'h00);
    eoi();

    // Level-triggered line re-grants after each EOI; reset clears it all.
    wr(16'h0023, 8'h04);
    rdchk("t5_tmr", 16'h0023, 8'h04);
    t0 = ntog;
    push(8'h0A, cyc + 3);
    req = 8'h04;
    repeat (4) tick();
    rdchk("t5_isr", 16'h0022, 8'h04);
    rdchk("t5_irr_set_wins", 16'h0020, 8'h04);
    push(8'h0A, cyc + 2);
    eoi();
    tick();
    tick();
    tick();
    push(8'h0A, cyc + 2);
    eoi();
    tick();
    tick();
    tick();
    check("t5_regrants", ntog, t0 + 3);
    check("t5_irq_pre", {31'h0, irq}, 32'h1);
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check("t5_rst_irq", {31'h0, irq}, 32'h0);
    check("t5_rst_irq_in", {24'h0, irq_in}, 32'h08);
    rdchk("t5_rst_isr", 16'h0022, 8'h00);
    rdchk("t5_rst_tmr", 16'h0023, 8'h00);
    t1 = ntog;
    repeat (6) tick();
    check("t5_held_no_grant", ntog, t1);
    rdchk("t5_held_irr", 16'h0020, 8'h00);
    req = 8'h00;
    tick();
    tick();
    push(8'h0A, cyc + 3);
    req = 8'h04;
    repeat (4) tick();
    check("t5_rise_grant", ntog, t1 + 1);
    req = 8'h00;
    eoi();
    tick();
    tick();

    check("sb_empty", sb.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pic_ctrl.md
PIC_CTRL -- requirements
Module: pic_ctrl

Interface
REQ-001 Parameter VECTOR_BASE, default 8'h08, vector delivered for line 0; line n delivers VECTOR_BASE+n.
REQ-002 Parameter PORT_BASE, default 16'h0020, base I/O address of the controller's four registers.
REQ-003 clock  input  1  single system clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 port_a  input  16  CPU I/O address.
REQ-006 port_w  input  1  one-cycle I/O write strobe.
REQ-007 port_r  input  1  one-cycle I/O read strobe.
REQ-008 port_o  input  8  CPU write data.
REQ-009 port_i  output  8  read data for controller addresses, 8'hFF otherwise.
REQ-010 req  input  8  interrupt request lines; bit 0 = timer, bit 1 = keyboard, bit 2 = vertical retrace.
REQ-011 irq  output  1  toggle signal to the CPU; every change of level means one new interrupt.
REQ-012 irq_in  output  8  vector number, stable from the toggle until the next toggle.

Function
REQ-013 Register map:
- PORT_BASE+0 write 8'h20 = non-specific EOI; other values are ignored; read = IRR.
- PORT_BASE+1 read/write = IMR (1 = masked).
- PORT_BASE+2 read = ISR, write ignored.
- PORT_BASE+3 read/write = trigger mode TMR (1 = level, 0 = edge).
REQ-014 Edge line: a 0->1 transition of req[n] (previous-cycle sample 0, current 1) sets IRR[n] at the next edge.
REQ-015 Level line: req[n]=1 sets IRR[n] every cycle while high.
REQ-016 A repeated request on an already-set IRR bit merges into it; there is no counting.
REQ-017 Masked lines still latch into IRR; they are not granted until unmasked.
REQ-018 Two-state FSM:
- IDLE (ISR==0): if (IRR & ~IMR) != 0, grant the lowest-numbered such line n on the same edge.
- Grant actions: irq toggles, irq_in <= VECTOR_BASE+n, ISR[n] <= 1, IRR[n] <= 0, go to SERVICE.
REQ-019 SERVICE (ISR!=0): no new grant is issued.
- EOI clears ISR and returns to IDLE.
- A grant may occur no earlier than the edge after EOI.
REQ-020 Latency: an edge request whose rising sample is at edge N causes IRR set at N+1 and irq toggle at N+2, if IDLE and unmasked.
REQ-021 On simultaneous set and grant-clear of the same IRR bit, the set wins and the bit stays pending.
REQ-022 EOI received in IDLE is ignored.
REQ-023 An IMR write in the same cycle as a grant uses the old IMR.
REQ-024 port_i is combinational from port_a and current registers; port_r has no side effects.
REQ-025 Vector arithmetic is 8-bit modulo 256.

Reset
REQ-026 On reset the following take effect at the next edge, overriding any in-progress grant, EOI or port write:
- irq=0, irq_in=VECTOR_BASE.
- IRR=0, ISR=0, IMR=8'h00, TMR=8'h00.
- req previous-sample register = 0.
- FSM = IDLE.
REQ-027 A req line held high through reset release registers one edge request only on a new 0->1 transition after release.

Structure
REQ-028 A shared package holds the register offset constants (OFS_CMD=0, OFS_IMR=1, OFS_ISR=2, OFS_TMR=3), EOI_CMD=8'h20, and the FSM state encoding.
REQ-029 One sub-module, pic_edge: an 8-bit sampler that outputs the per-line set pulses from req and TMR; priority select and registers remain in pic_ctrl.

Verification
REQ-030 Reset, then a one-cycle pulse on req[1]:
- irq 0->1 two edges later, irq_in=8'h09, ISR=8'h02, IRR=0.
REQ-031 req[0] and req[2] pulsed in the same cycle:
- grant vector 8'h08 first.
- Write 8'h20 to 16'h0020 -> next grant 8'h0A one edge later; irq toggles twice total.
REQ-032 IMR=8'h01, then pulse req[0]:
- IRR=8'h01 and no toggle.
- Write IMR=8'h00 -> toggle with irq_in=8'h08 on the next edge.
REQ-033 In SERVICE, pulse req[1] three times:
- IRR[1] stays 1 and there is no toggle.
- After EOI exactly one grant of 8'h09 occurs.
REQ-034 TMR[2]=1, req[2] held high:
- grant 8'h0A; after EOI, IRR[2] re-sets and it is re-granted.
- Assert reset mid-SERVICE -> irq=0, ISR=0, no grant until req[2] rises again after TMR is reprogrammed.
